// File: rtl/mem_port_arbiter.sv
// Byte-wide memory bank shared by the fetch port and the data load/store port; word accesses run as four beats.
// Build option: define ROUND_ROBIN_EN for alternating grants on collisions (default is fixed dm-over-fetch priority).
module mem_port_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ack,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_TAIL = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Big-endian byte pick: index 0 is the most significant byte.
    function automatic logic [7:0] f_byte_sel(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    f_byte_sel = word[31:24];
            2'd1:    f_byte_sel = word[23:16];
            2'd2:    f_byte_sel = word[15:8];
            2'd3:    f_byte_sel = word[7:0];
            default: f_byte_sel = 8'h00;
        endcase
    endfunction

    state_t              r_state;
    logic [1:0]          r_beat;
    logic                r_port_dm;
    logic                r_we;
    logic [ADDR_W-3:0]   r_base;
    logic [31:0]         r_wdata;
    logic [23:0]         r_rdbuf;
    logic                r_if_ack, r_dm_ack, r_err, r_busy;
    logic                r_mem_en, r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic [31:0]         r_if_rdata, r_dm_rdata;

    logic                w_grant_dm;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic                w_gnt_we;
    state_t              w_state_nxt;
    logic [1:0]          w_beat_nxt;
    logic                w_port_nxt;
    logic                w_we_nxt;
    logic [ADDR_W-3:0]   w_base_nxt;
    logic [31:0]         w_wdata_nxt;
    logic                w_mis;
    logic                w_mem_en_nxt, w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [7:0]          w_mem_wdata_nxt;
    logic                w_resp_nxt;
    logic [31:0]         w_load_word;

`ifdef ROUND_ROBIN_EN
    logic                r_last_dm;

    // Collision winner alternates; a lone request always wins.
    always_comb begin
        w_grant_dm = 1'b0;
        if (dm_req && if_req) begin
            w_grant_dm = ~r_last_dm;
        end else begin
            w_grant_dm = dm_req;
        end
    end

    // Remember which port won the most recent grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_dm <= 1'b0;
        end else if (r_state == S_IDLE && (if_req || dm_req)) begin
            r_last_dm <= w_grant_dm;
        end else begin
            r_last_dm <= r_last_dm;
        end
    end
`else
    // Fixed priority: the data port always beats the fetch port.
    always_comb begin
        w_grant_dm = 1'b0;
        w_grant_dm = dm_req;
    end
`endif

    assign w_gnt_addr  = w_grant_dm ? dm_addr : if_addr;
    assign w_gnt_we    = w_grant_dm & dm_we;
    assign w_load_word = {r_rdbuf, mem_rdata};

    // Next-state and next-context logic.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_port_nxt  = r_port_dm;
        w_we_nxt    = r_we;
        w_base_nxt  = r_base;
        w_wdata_nxt = r_wdata;
        w_mis       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    w_port_nxt  = w_grant_dm;
                    w_we_nxt    = w_gnt_we;
                    w_base_nxt  = w_gnt_addr[ADDR_W-1:2];
                    w_wdata_nxt = dm_wdata;
                    w_beat_nxt  = 2'd0;
                    if (w_gnt_addr[1:0] != 2'd0) begin
                        w_mis       = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_XFER;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_XFER: begin
                if (r_beat == 2'd3) begin
                    w_state_nxt = r_we ? S_RESP : S_TAIL;
                end else begin
                    w_beat_nxt  = r_beat + 2'd1;
                    w_state_nxt = S_XFER;
                end
            end
            S_TAIL:  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state so they can be registered.
    always_comb begin
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = 8'h00;
        if (w_state_nxt == S_XFER) begin
            w_mem_en_nxt    = 1'b1;
            w_mem_we_nxt    = w_we_nxt;
            w_mem_addr_nxt  = {w_base_nxt, w_beat_nxt};
            w_mem_wdata_nxt = w_we_nxt ? f_byte_sel(w_wdata_nxt, w_beat_nxt) : 8'h00;
        end else begin
            w_mem_en_nxt    = 1'b0;
        end
        w_resp_nxt = (w_state_nxt == S_RESP);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Access context latched on the grant edge, beat counter advanced per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat    <= 2'd0;
            r_port_dm <= 1'b0;
            r_we      <= 1'b0;
            r_base    <= '0;
            r_wdata   <= 32'h0;
        end else begin
            r_beat    <= w_beat_nxt;
            r_port_dm <= w_port_nxt;
            r_we      <= w_we_nxt;
            r_base    <= w_base_nxt;
            r_wdata   <= w_wdata_nxt;
        end
    end

    // Read bytes arrive one beat late: beat n captures the byte of beat n-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdbuf <= 24'h0;
        end else if (r_state == S_XFER && !r_we) begin
            case (r_beat)
                2'd1:    r_rdbuf[23:16] <= mem_rdata;
                2'd2:    r_rdbuf[15:8]  <= mem_rdata;
                2'd3:    r_rdbuf[7:0]   <= mem_rdata;
                default: r_rdbuf        <= r_rdbuf;
            endcase
        end else begin
            r_rdbuf <= r_rdbuf;
        end
    end

    // Registered bank strobes, handshake outputs and held read words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_dm_rdata  <= 32'h0;
        end else begin
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_ack    <= w_resp_nxt & ~w_port_nxt;
            r_dm_ack    <= w_resp_nxt & w_port_nxt;
            r_err       <= w_mis;
            r_busy      <= (w_state_nxt != S_IDLE);
            if (r_state == S_TAIL) begin
                if (r_port_dm) begin
                    r_dm_rdata <= w_load_word;
                end else begin
                    r_if_rdata <= w_load_word;
                end
            end else begin
                r_if_rdata <= r_if_rdata;
                r_dm_rdata <= r_dm_rdata;
            end
        end
    end

    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign err       = r_err;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, byte-wide memory bank between the instruction-fetch port and the data load/store port of the control unit.
- Sequences every 32-bit word access as four byte beats.
- Assembles read data big-endian: the byte at the base address goes to [31:24].
- Arbitrates simultaneous requests and returns a one-cycle ack per access.

Parameters:
- ADDR_W, 12, byte-address width of the shared bank (4096 bytes).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  32  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, level, held until dm_ack
- dm_we  in  1  1 = store word, 0 = load word
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load word, valid while dm_ack=1
- dm_ack  out  1  one-cycle data completion pulse
- err  out  1  misaligned-access flag, qualified by either ack
- mem_en  out  1  bank access strobe
- mem_we  out  1  bank byte write
- mem_addr  out  ADDR_W  bank byte address
- mem_wdata  out  8  bank write byte
- mem_rdata  in  8  bank read byte, valid one cycle after mem_en=1, mem_we=0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - All outputs are 0: acks, err, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, busy.
  - Arbitration history is cleared to "fetch granted last".
  - An access in flight is abandoned; a store may leave its word partially written.
- States: IDLE, XFER, TAIL, RESP.
- Requests are sampled only in IDLE. The winner's address, we and wdata are latched on the grant edge.
- Grant, cycle 0 = IDLE with a request:
  - Aligned address (addr[1:0]=0): next state is XFER, beat=0.
  - Misaligned address: next state is RESP with err=1 and no memory access, so ack is 1 cycle after grant.
- XFER, cycles 1-4, beat 0..3:
  - mem_en=1.
  - mem_addr={base[ADDR_W-1:2], beat[1:0]}, so an access never crosses a word boundary and there is no wrap.
  - Store: mem_we=1, mem_wdata=wdata byte (beat 0 -> [31:24] ... beat 3 -> [7:0]). After beat 3 go to RESP.
  - Load: mem_we=0. The byte for beat n-1 is captured during beat n. After beat 3 go to TAIL.
- TAIL, cycle 5, loads only: mem_en=0; capture byte 3 into [7:0]; go to RESP.
- RESP: the winner's ack=1 for exactly one cycle, with rdata valid (loads) and err valid; next state is IDLE.
- Latency from the grant edge to ack: load 6 cycles, store 5 cycles, misaligned 1 cycle. Back-to-back throughput is one access per 7 (load) or 6 (store) cycles.
- Requester handshake:
  - Keep req, addr, we and wdata stable until ack.
  - Drop req on the edge that samples ack. A req still high in the following IDLE is treated as a new access.
- if_rdata/dm_rdata hold their last value after ack.
- err is 0 except during a RESP entered from a misaligned grant.
- Fixed priority, without the optional feature: on simultaneous requests dm wins and the fetch waits in IDLE. No starvation guarantee.
- dm_we is ignored for fetch; the fetch port is read-only.
- Request inputs that change outside IDLE have no effect until the next IDLE.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- When defined:
  - Simultaneous requests are granted to the port not granted last; a 1-bit last-grant register updates on every grant.
  - A lone request is always granted.
- When undefined: the fixed dm-over-if priority described in Behaviour applies, and the last-grant register is absent.

Test Plan:
- Aligned load: preload bytes 0x12,0x34,0x56,0x78 at 0x010; dm_req, dm_we=0, dm_addr=0x010 -> dm_ack 6 cycles after grant, dm_rdata=0x12345678, err=0, mem_addr sequence 0x010..0x013.
- Aligned store: dm_we=1, dm_addr=0x008, dm_wdata=0xDEADBEEF -> 4 beats with mem_wdata DE,AD,BE,EF; dm_ack 5 cycles after grant; a follow-up fetch from 0x008 returns 0xDEADBEEF.
- Contention: if_req and dm_req raised in the same cycle (if 0x000, dm 0x004) -> dm served first, then the fetch. With ROUND_ROBIN_EN and a repeated collision, the grant alternates.
- Misaligned: if_addr=0x006 -> if_ack 1 cycle after grant, err=1, mem_en never asserted.
- Reset mid-store: rst=0 during beat 2 -> immediate IDLE, all outputs 0, bytes 0-1 written and 2-3 unchanged. After release, a new load completes normally.
- Held request: keep if_req high across if_ack -> a second fetch is granted in the next IDLE cycle and completes with a correct ack.
